// File: rtl/ita_package.sv
// rtl/ita_package.sv - shared ITA widths and reciprocal-divider state type (ITA_RECIP_DIV_ROUND_EN adds ROUND)
package ita_package;

   localparam int unsigned SoftmaxAccDataWidth = 19;
   localparam int unsigned DividerWidth        = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
`ifdef ITA_RECIP_DIV_ROUND_EN
      ROUND = 2'd2,
`endif
      DONE  = 2'd3
   } recip_div_state_e;

endpackage

// File: rtl/ita_recip_div.sv
// rtl/ita_recip_div.sv - constant-dividend restoring divider, NumVal / divisor, MSB first
// ITA_RECIP_DIV_ROUND_EN: round half up in an extra ROUND cycle instead of truncating
module ita_recip_div
   import ita_package::*;
#(
   parameter int unsigned             InWidth  = SoftmaxAccDataWidth,
   parameter int unsigned             OutWidth = DividerWidth,
   parameter logic [OutWidth-1:0]     NumVal   = OutWidth'(1 << (OutWidth - 1))
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [InWidth-1:0]  div_inp_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [OutWidth-1:0] div_oup_o,
   output logic                valid_o,
   input  logic                ready_i
);

   localparam int unsigned CntW = (OutWidth > 1) ? $clog2(OutWidth) : 1;

   recip_div_state_e    state_q;
   logic                ready_q;
   logic                valid_q;
   logic [OutWidth-1:0] quot_q;
   logic [InWidth:0]    rem_q;
   logic [InWidth-1:0]  divisor_q;
   logic [OutWidth-1:0] dvd_q;
   logic [CntW-1:0]     cnt_q;

   logic [InWidth:0]    rem_shift;
   logic [InWidth:0]    rem_sub;
   logic                step_ge;

   // rem_q never exceeds divisor-1, so dropping its top bit in the shift is lossless
   assign rem_shift = {rem_q[InWidth-1:0], dvd_q[OutWidth-1]};
   assign step_ge   = {rem_q, dvd_q[OutWidth-1]} >= {2'b00, divisor_q};
   assign rem_sub   = rem_shift - {1'b0, divisor_q};

`ifdef ITA_RECIP_DIV_ROUND_EN
   logic round_up;
   assign round_up = {rem_q, 1'b0} >= {2'b00, divisor_q};
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         dvd_q     <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  divisor_q <= div_inp_i;
                  dvd_q     <= NumVal;
                  rem_q     <= '0;
                  cnt_q     <= CntW'(OutWidth - 1);
                  ready_q   <= 1'b0;
                  if (div_inp_i == '0) begin
                     quot_q  <= '1;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q  <= step_ge ? rem_sub : rem_shift;
               quot_q <= {quot_q[OutWidth-2:0], step_ge};
               dvd_q  <= {dvd_q[OutWidth-2:0], 1'b0};
               cnt_q  <= cnt_q - CntW'(1);
               if (cnt_q == '0) begin
`ifdef ITA_RECIP_DIV_ROUND_EN
                  state_q <= ROUND;
`else
                  valid_q <= 1'b1;
                  state_q <= DONE;
`endif
               end
            end
`ifdef ITA_RECIP_DIV_ROUND_EN
            ROUND: begin
               if (round_up) begin
                  quot_q <= quot_q + OutWidth'(1);
               end
               valid_q <= 1'b1;
               state_q <= DONE;
            end
`endif
            DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready_o   = ready_q;
   assign valid_o   = valid_q;
   assign div_oup_o = quot_q;

endmodule

// File: doc/ita_recip_div.md
ITA_RECIP_DIV -- requirements
Module: ita_recip_div

Interface
REQ-001 Parameter InWidth, default SoftmaxAccDataWidth: divisor (exp-sum) width.
REQ-002 Parameter OutWidth, default DividerWidth: quotient width.
REQ-003 Parameter NumVal, default 2**(OutWidth-1), OutWidth bits: constant dividend.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk_i, input, 1: rising-edge clock.
REQ-006 Port rst_i, input, 1: asynchronous active-high reset.
REQ-007 Port div_inp_i, input, InWidth: divisor.
REQ-008 Port valid_i, input, 1: divisor valid.
REQ-009 Port ready_o, output, 1: block can accept a divisor.
REQ-010 Port div_oup_o, output, OutWidth: quotient.
REQ-011 Port valid_o, output, 1: quotient valid.
REQ-012 Port ready_i, input, 1: consumer accepts the quotient.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, ROUND (only when the macro is on) and DONE.
REQ-014 In IDLE, ready_o=1; in all other states ready_o=0, so a new divisor is never accepted while a result is outstanding.
REQ-015 On valid_i&&ready_o, the block SHALL latch the divisor and load a dividend shift register with NumVal.
- It SHALL also clear the remainder (InWidth+1 bits) and set the bit counter to OutWidth-1.
REQ-016 Transition on accept: to CALC if the divisor is non-zero; to DONE with div_oup_o='1 if the divisor is zero.
REQ-017 Each CALC cycle SHALL perform one restoring step, MSB first.
- rem = {rem, dividend MSB}; if rem >= divisor then rem -= divisor and quotient bit = 1, else 0.
- Shift dividend and quotient; decrement counter.
REQ-018 After exactly OutWidth CALC cycles, the FSM SHALL go to ROUND (macro on) or DONE (macro off).
REQ-019 Latency, accept edge to first valid_o cycle: OutWidth+1 cycles (macro off), OutWidth+2 (macro on), 1 for a zero divisor.
REQ-020 In DONE, valid_o=1 and div_oup_o SHALL be held stable until ready_i=1; valid_o&&ready_i then returns the FSM to IDLE.
REQ-021 In DONE, ready_o SHALL stay 0 even when ready_i=1; the next accept is possible one cycle later, in IDLE.
REQ-022 div_oup_o SHALL equal floor(NumVal/divisor), which always fits in OutWidth bits; no saturation is required.
REQ-023 valid_i while busy SHALL be ignored; the upstream holds valid_i until ready_o.
REQ-024 div_oup_o SHALL hold the last result in IDLE.

Reset
REQ-025 While rst_i=1, at any point including mid-CALC, the block SHALL be in state IDLE with:
- ready_o=1 and valid_o=0;
- div_oup_o, remainder, divisor, dividend and counter registers = 0.
REQ-026 The first accept is possible on the first clock edge after rst_i deasserts.

Configuration
REQ-027 Macro ITA_RECIP_DIV_ROUND_EN SHALL select the rounding behaviour.
- Defined: the ROUND state adds 1 to the quotient when 2*rem >= divisor (round half up), giving one extra cycle of latency.
- Undefined: ROUND state is absent, the result is truncated, and latency is OutWidth+1.
REQ-028 The rounded result cannot exceed NumVal (divisor 1 gives rem 0), so no overflow handling is required.

Structure
REQ-029 The state enum typedef (recip_div_state_e) SHALL live in ita_package, alongside SoftmaxAccDataWidth and DividerWidth.
REQ-030 No sub-module SHALL be used: single FSM plus datapath, and ita_softmax instantiates NumDiv copies in round-robin.

Verification
REQ-031 Test values use InWidth=16, OutWidth=16, NumVal=16'h8000.
REQ-032 Truncation: divisor 256, macro off -> div_oup_o=128, valid_o rises 17 cycles after accept.
REQ-033 Rounding: divisor 3 -> 10922 with macro off; 10923 with ITA_RECIP_DIV_ROUND_EN, valid_o at cycle 18.
REQ-034 Zero divisor: divisor 0 -> div_oup_o=16'hFFFF, valid_o 1 cycle after accept.
REQ-035 Backpressure: divisor 1, ready_i held low 5 cycles after valid_o.
- div_oup_o=16'h8000 stays stable and valid_o stays 1.
- ready_o stays 0 throughout.
- IDLE is entered on the cycle after ready_i rises.
REQ-036 Mid-op reset: assert rst_i during CALC cycle 7 -> valid_o=0 and ready_o=1 at once.
- A new divisor of 2 after release returns 16384.
REQ-037 Busy ignore: valid_i with divisor 5 held during CALC -> ignored until IDLE, then accepted; result 6553 (truncated).
